// File: rtl/digit_frame_streamer_pkg.sv
// Shared constants, segment payload and FSM state type for the digit frame streamer.
package digit_frame_streamer_pkg;

  localparam int unsigned NUM_DIGITS  = 6;
  localparam int unsigned DIGIT_WIDTH = 21;
  localparam int unsigned LEFT_MARGIN = 1;
  localparam int unsigned NUM_COLUMNS = 128;
  localparam int unsigned NUM_PAGES   = 4;

  // First column past the last digit; everything from here to the panel edge is margin.
  localparam int unsigned DIGIT_END = LEFT_MARGIN + NUM_DIGITS * DIGIT_WIDTH;

  localparam int unsigned COL_W  = $clog2(NUM_COLUMNS);
  localparam int unsigned PAGE_W = $clog2(NUM_PAGES);
  localparam int unsigned X_W    = 5;
  localparam int unsigned D_W    = $clog2(NUM_DIGITS + 1);
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned BYTE_W = 8;

  // Segment a is the MSB, so the struct doubles as a 7-bit {a..g} vector.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } segments_t;

  localparam segments_t SEG_BLANK = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_frame_streamer_frame_cursor.sv
// Page/column cursor with digit and in-digit counters; no division anywhere.
module digit_frame_streamer_frame_cursor
  import digit_frame_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [PAGE_W-1:0] o_page,
  output logic [COL_W-1:0]  o_col,
  output logic [D_W-1:0]    o_digit,
  output logic [X_W-1:0]    o_x,
  output logic              o_margin,
  output logic              o_last
);

  logic [PAGE_W-1:0] r_page;
  logic [COL_W-1:0]  r_col;
  logic [D_W-1:0]    r_digit;
  logic [X_W-1:0]    r_x;
  logic              w_margin;
  logic              w_col_end;
  logic              w_last;

  assign w_margin  = (r_col < COL_W'(LEFT_MARGIN)) || (r_col >= COL_W'(DIGIT_END));
  assign w_col_end = (r_col == COL_W'(NUM_COLUMNS - 1));
  assign w_last    = w_col_end && (r_page == PAGE_W'(NUM_PAGES - 1));

  // Advance the cursor; digit/x only move while the current column is inside a digit.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_page  <= '0;
      r_col   <= '0;
      r_digit <= '0;
      r_x     <= '0;
    end else if (i_advance && !w_last) begin
      if (w_col_end) begin
        r_col   <= '0;
        r_page  <= r_page + PAGE_W'(1);
        r_digit <= '0;
        r_x     <= '0;
      end else begin
        r_col <= r_col + COL_W'(1);
        if (!w_margin) begin
          if (r_x == X_W'(DIGIT_WIDTH - 1)) begin
            r_x     <= '0;
            r_digit <= r_digit + D_W'(1);
          end else begin
            r_x <= r_x + X_W'(1);
          end
        end
      end
    end
  end

  assign o_page   = r_page;
  assign o_col    = r_col;
  assign o_digit  = r_digit;
  assign o_x      = r_x;
  assign o_margin = w_margin;
  assign o_last   = w_last;

endmodule

// File: rtl/digit_frame_streamer.sv
// Streams the 512-byte SSD1306 frame for a row of 7-segment digits over valid/ready.
module digit_frame_streamer
  import digit_frame_streamer_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  segments_t [NUM_DIGITS-1:0]       digits_in,
  output segments_t                        seg_out,
  output logic [X_W-1:0]                   index_x,
  output logic [PAGE_W-1:0]                index_y,
  input  logic [BYTE_W-1:0]                pixels_in,
  output logic [BYTE_W-1:0]                data_out,
  output logic                             data_valid,
  input  logic                             data_ready,
  output logic                             busy,
  output logic                             frame_done
);

  state_t                      r_state;
  segments_t [NUM_DIGITS-1:0]  r_digits;
  logic [BYTE_W-1:0]           r_data_out;
  logic                        r_data_valid;
  logic                        r_busy;
  logic                        r_frame_done;

  logic                        w_load;
  logic                        w_clear;
  logic [PAGE_W-1:0]           w_page;
  logic [COL_W-1:0]            w_col;
  logic [D_W-1:0]              w_digit;
  logic [X_W-1:0]              w_x;
  logic                        w_margin;
  logic                        w_last;
  segments_t                   w_seg;

  assign w_load  = (r_state == ST_STREAM) && (!r_data_valid || data_ready);
  assign w_clear = (r_state == ST_IDLE) && start;

  digit_frame_streamer_frame_cursor u_cursor (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_clear),
    .i_advance (w_load),
    .o_page    (w_page),
    .o_col     (w_col),
    .o_digit   (w_digit),
    .o_x       (w_x),
    .o_margin  (w_margin),
    .o_last    (w_last)
  );

  // Decoder drive: blank segments and x=0 in the margins, latched digit otherwise.
  always_comb begin
    w_seg   = SEG_BLANK;
    index_x = '0;
    index_y = w_page;
    if (!w_margin && (w_digit < D_W'(NUM_DIGITS))) begin
      w_seg   = r_digits[w_digit];
      index_x = w_x;
    end
  end

  assign seg_out = w_seg;

  // Streamer FSM with registered byte, valid, busy and frame_done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_digits     <= {NUM_DIGITS{SEG_BLANK}};
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_digits <= digits_in;
            r_busy   <= 1'b1;
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_load) begin
            r_data_out   <= w_margin ? '0 : pixels_in;
            r_data_valid <= 1'b1;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_data_valid && data_ready) begin
            r_data_valid <= 1'b0;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // w_col is only used for visibility in the cursor; keep it referenced.
  logic w_col_unused;
  assign w_col_unused = ^w_col;

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_frame_streamer.sv
// Directed bench for digit_frame_streamer using an in-bench decoder model.
module tb_digit_frame_streamer;
  import digit_frame_streamer_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       start;
  segments_t [NUM_DIGITS-1:0] digits_in;
  segments_t                  seg_out;
  logic [4:0]                 index_x;
  logic [1:0]                 index_y;
  logic [7:0]                 pixels_in;
  logic [7:0]                 data_out;
  logic                       data_valid;
  logic                       data_ready;
  logic                       busy;
  logic                       frame_done;

  // 0: echo decoder {1, page, x}; 1: segment decoder {1, seg}
  logic seg_mode;

  always #5 clk = ~clk;

  assign pixels_in = seg_mode ? {1'b1, seg_out} : {1'b1, index_y, index_x};

  digit_frame_streamer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .digits_in  (digits_in),
    .seg_out    (seg_out),
    .index_x    (index_x),
    .index_y    (index_y),
    .pixels_in  (pixels_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] got     [512];
  logic [7:0] ref_got [512];
  int n_acc, done_cnt, stall_err, seg_err, first_valid;

  localparam logic [41:0] DIG_A = 42'h2A5F0C396E1;
  localparam logic [41:0] DIG_B = ~DIG_A;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame byte i for the given decoder mode and latched digits.
  function automatic logic [7:0] model_byte(input int i, input bit mode, input logic [41:0] digs);
    int page;
    int col;
    int d;
    int x;
    page = i / 128;
    col  = i % 128;
    if (col < 1 || col >= 127) return 8'h00;
    d = (col - 1) / 21;
    x = (col - 1) % 21;
    if (mode) return {1'b1, 7'(digs >> (7 * d))};
    return {1'b1, 2'(page), 5'(x)};
  endfunction

  // Pulse start and collect accepted bytes until frame_done (or reset point / timeout).
  task automatic run_frame(input bit stall, input int repulse_at, input int change_at,
                           input logic [41:0] new_digits, input int reset_at, input bit chk_blank);
    bit         prev_stall;
    logic [7:0] prev_data;
    n_acc = 0; done_cnt = 0; stall_err = 0; seg_err = 0; first_valid = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (chk_blank && (seg_out !== SEG_BLANK)) seg_err++;
      if (data_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!data_valid || data_out !== prev_data)) stall_err++;
      if (frame_done) begin
        done_cnt++;
        break;
      end
      if (reset_at >= 0 && n_acc == reset_at) return;
      data_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = data_valid && !data_ready;
      prev_data  = data_out;
      if (data_valid && data_ready) begin
        if (n_acc < 512) got[n_acc] = data_out;
        n_acc++;
        if (n_acc == repulse_at) start = 1'b1;
        if (n_acc == change_at) digits_in = new_digits;
      end
    end
  endtask

  task automatic verify_frame(input string name, input bit mode, input logic [41:0] digs);
    int mism;
    mism = 0;
    for (int i = 0; i < 512; i++) begin
      if (got[i] !== model_byte(i, mode, digs)) mism++;
    end
    check({name, "_count"},   n_acc, 512);
    check({name, "_bytes"},   mism, 0);
    check({name, "_done"},    done_cnt, 1);
    check({name, "_stall"},   stall_err, 0);
    check({name, "_latency"}, first_valid, 2);
  endtask

  initial begin
    int diff;
    reset_n    = 1'b0;
    start      = 1'b0;
    data_ready = 1'b1;
    seg_mode   = 1'b0;
    digits_in  = DIG_A;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", data_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_data",  data_out, 0);
    check("rst_done",  frame_done, 0);
    check("rst_seg",   seg_out, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // echo decoder, ready held high
    run_frame(1'b0, -1, -1, '0, -1, 1'b0);
    verify_frame("echo", 1'b0, DIG_A);
    check("echo_col0",    got[0], 8'h00);
    check("echo_col1",    got[1], 8'h80);
    check("echo_col22",   got[22], 8'h80);
    check("echo_p2c126",  got[2 * 128 + 126], 8'hD4);
    check("echo_col127",  got[127], 8'h00);
    check("echo_p3c127",  got[511], 8'h00);
    check("echo_busy_end", busy, 0);
    for (int i = 0; i < 512; i++) ref_got[i] = got[i];

    // random backpressure
    run_frame(1'b1, -1, -1, '0, -1, 1'b0);
    verify_frame("stall", 1'b0, DIG_A);
    diff = 0;
    for (int i = 0; i < 512; i++) if (got[i] !== ref_got[i]) diff++;
    check("stall_vs_echo", diff, 0);
    data_ready = 1'b1;

    // all digits blank, segment decoder
    seg_mode  = 1'b1;
    digits_in = '0;
    run_frame(1'b0, -1, -1, '0, -1, 1'b1);
    verify_frame("blank", 1'b1, 42'h0);
    check("blank_seg", seg_err, 0);
    check("blank_col1", got[1], 8'h80);

    // start re-pulsed mid-frame
    seg_mode  = 1'b0;
    digits_in = DIG_A;
    run_frame(1'b0, 100, -1, '0, -1, 1'b0);
    verify_frame("repulse", 1'b0, DIG_A);

    // digits changed mid-frame
    seg_mode  = 1'b1;
    digits_in = DIG_A;
    run_frame(1'b0, -1, 200, DIG_B, -1, 1'b0);
    verify_frame("latched", 1'b1, DIG_A);

    // reset in the middle of a frame
    seg_mode  = 1'b0;
    digits_in = DIG_A;
    run_frame(1'b0, -1, -1, '0, 300, 1'b0);
    check("mid_reached", n_acc, 300);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_done",  frame_done, 0);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (frame_done || busy || data_valid) done_cnt++;
    end
    check("mid_rst_quiet", done_cnt, 0);
    run_frame(1'b0, -1, -1, '0, -1, 1'b0);
    verify_frame("after_rst", 1'b0, DIG_A);
    check("after_rst_col0", got[0], 8'h00);
    check("after_rst_col1", got[1], 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_frame_streamer.md
Name: digit_frame_streamer

Overview:
Converts a row of latched 7-segment digit codes into the 512-byte SSD1306 frame for a 128x32 panel, in horizontal-addressing order (page 0 col 0..127, then page 1, ...). It drives the 21x32 digit pixel decoder (a combinational stage) with segments and indices, and registers the returned byte. It presents each byte on a valid/ready stream to the display transport (I2C/SPI byte sender). It sits between the frequency-to-BCD/7-seg stage and the display link.

Parameters:
NUM_DIGITS, 6, digits per frame; digit 0 is leftmost.
DIGIT_WIDTH, 21, columns per digit; matches the decoder.
LEFT_MARGIN, 1, blank columns before digit 0.
NUM_COLUMNS, 128, panel width.
NUM_PAGES, 4, 8-pixel pages; matches decoder index_y range.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
start  in  1  one-cycle request to stream a frame
digits_in  in  NUM_DIGITS x Segments  digit segment codes; sampled on accepted start
seg_out  out  Segments  segments of the current digit, to decoder
index_x  out  5  column within the digit (0..DIGIT_WIDTH-1), to decoder
index_y  out  2  current page, to decoder
pixels_in  in  8  decoder result for (seg_out, index_x, index_y), same cycle
data_out  out  8  frame byte
data_valid  out  1  data_out is valid
data_ready  in  1  transport accepts data_out
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset (reset_n=0 on a clock edge):
  - state=IDLE; data_valid=0, data_out=0, busy=0, frame_done=0.
  - Cursor page=0, col=0. Latched digits cleared to blank.
  - Applies mid-frame: the frame is abandoned and no frame_done is produced.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - start=1: latch digits_in, reset cursor, go to STREAM next cycle.
  - start while busy is ignored.
- Cursor is counters only (no divider):
  - page 0..NUM_PAGES-1, col 0..NUM_COLUMNS-1.
  - Digit counter d and in-digit counter x advance with col. x wraps DIGIT_WIDTH-1 -> 0 and increments d.
  - Margin: col < LEFT_MARGIN, or col >= LEFT_MARGIN + NUM_DIGITS*DIGIT_WIDTH.
  - In margin: seg_out = blank, index_x=0, and the loaded byte is forced to 0x00 regardless of pixels_in.
  - Otherwise: seg_out = latched digit d, index_x = x, index_y = page.
- Load condition: (state==STREAM) && (!data_valid || data_ready).
  - On load: data_out <= margin ? 0x00 : pixels_in; data_valid <= 1; cursor advances.
  - col wraps 127 -> 0 and increments page.
- Last byte is (page 3, col 127). Loading it moves the state to DRAIN; the cursor holds.
- Output holding rule: while data_valid=1 and data_ready=0, data_out and data_valid hold stable and the cursor does not move.
- DRAIN:
  - When data_valid && data_ready: data_valid <= 0, frame_done=1 for one cycle, state <= IDLE.
  - busy drops the same cycle frame_done is high.
- Throughput: one byte per clock with ready held high.
- Latency: first byte valid 2 cycles after start (one cycle latch, one cycle load). Exactly 512 bytes per frame.
- digits_in changes during a frame have no effect.

Decomposition:
- Shared package holds:
  - Segments packed struct (a..g, also accessible as a vector);
  - SEG_BLANK constant;
  - DIGIT_WIDTH, NUM_PAGES, NUM_COLUMNS constants shared with the decoder.
- Sub-module frame_cursor holds the page/col/digit/x counters, margin flag and last flag, with an advance input.
- The streamer FSM and output register stay in the top.

Test Plan:
- Echo model: bench decoder returns {1'b1, index_y, index_x}, data_ready=1, start pulse. Required bytes:
  - col 0 = 0x00;
  - col 1 page 0 = 0x80;
  - col 22 page 0 = 0x80 (digit 1, x=0);
  - col 126 page 2 = 0xD4;
  - col 127 = 0x00.
  - Also: exactly 512 bytes, frame_done once.
- Backpressure: data_ready toggled pseudo-randomly. Required: data_out stable while stalled, same 512-byte sequence as the unstalled run, no drops or duplicates.
- All digits SEG_BLANK. Required: seg_out blank throughout, frame_done after 512 accepted bytes.
- start re-pulsed at byte 100. Required: ignored; frame completes normally with 512 bytes.
- reset_n low at byte 300. Required: data_valid=0 and busy=0 next cycle, no frame_done. A new start produces a full 512-byte frame from page 0 col 0.
- digits_in changed mid-frame. Required: output still reflects the values latched at start.
